// File: rtl/lsu_master.sv
// MEM-stage load/store unit: turns pipeline ops into word-aligned bus
// transactions, stalls until the bus responds, returns extended load data.
module lsu_master #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TMAX = TM[CW-1:0];

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_f3;
  logic [1:0]      op_lo;

  logic             present;
  logic             both;
  logic             bad_f3;
  logic             misal;
  logic             legal;
  logic             tmo;
  logic [3:0]       be;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sh;
  logic [7:0]       b;
  logic [15:0]      h;
  logic [WIDTH-1:0] ext;

  always_comb begin
    present = mem_read ^ mem_write;
    both    = mem_read & mem_write;
    if (mem_read)
      bad_f3 = funct3 inside {3'b011, 3'b110, 3'b111};
    else
      bad_f3 = !(funct3 inside {3'b000, 3'b001, 3'b010});
    misal = (funct3[1:0] == 2'b01 && addr[0]) ||
            (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    legal = present && !bad_f3 && !misal;
  end

  // rvalid has priority over an expiring timeout
  assign tmo = (TIMEOUT != 0) && state == WAIT &&
               !mem_rvalid && cnt == TMAX;

  assign stall = (state == IDLE && legal) ||
                 state == REQ || state == WAIT;

  assign err = (state == IDLE &&
                (both || (present && (bad_f3 || misal)))) || tmo;

  always_comb begin
    be = 4'b1111;
    wd = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  always_comb begin
    sh  = mem_rdata >> {op_lo, 3'b000};
    b   = sh[7:0];
    h   = op_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext = mem_rdata;
    unique case (op_f3)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b100:  ext = {24'b0, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b101:  ext = {16'b0, h};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_f3     <= '0;
      op_lo     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (legal) begin
            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
            mem_we    <= mem_write;
            mem_be    <= be;
            mem_wdata <= mem_write ? wd : '0;
            op_f3     <= funct3;
            op_lo     <= addr[1:0];
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            rdata <= ext;
            state <= DONE;
          end else if (tmo) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: vector table through a bus-side scoreboard,
// plus reset-in-WAIT, timeout and back-to-back store/load sequences.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int hs = 0;
  logic [31:0] mem_m [0:255];

  always #5 clk = ~clk;

  lsu_master #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // bus monitor and tiny backing memory
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      hs <= hs + 1;
      if (mem_we)
        for (int k = 0; k < 4; k++)
          if (mem_be[k])
            mem_m[mem_addr[9:2]][k*8 +: 8] <= mem_wdata[k*8 +: 8];
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          gdly;
    int          rdly;
    logic [31:0] bus;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  bus_t        bus_q [$];
  logic [31:0] res_q [$];
  vec_t        tbl [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic run_op(input vec_t v);
    int st;
    bus_t e;
    mem_read  = v.rd;
    mem_write = v.wr;
    funct3    = v.f3;
    addr      = v.a;
    wdata     = v.wd;
    @(negedge clk);
    if (v.eerr) begin
      chk("err_flag", 32'(err), 1);
      chk("err_stall", 32'(stall), 0);
      chk("err_req", 32'(mem_req), 0);
      @(posedge clk); #1;
      clr_in();
      @(negedge clk);
      chk("err_idle_req", 32'(mem_req), 0);
      chk("err_idle_stall", 32'(stall), 0);
      chk("err_clear", 32'(err), 0);
      chk("err_rdata", rdata, v.erd);
      @(posedge clk); #1;
      return;
    end
    bus_q.push_back('{v.wr, {v.a[31:2], 2'b00}, v.be, v.ewd});
    res_q.push_back(v.erd);
    chk("idle_err", 32'(err), 0);
    st = int'(stall);
    @(posedge clk); #1;
    for (int i = 0; i <= v.gdly; i++) begin
      if (i == v.gdly) begin
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
      end
      @(negedge clk);
      chk("req_req", 32'(mem_req), 1);
      chk("req_err", 32'(err), 0);
      st += int'(stall);
      if (i == 0) begin
        e = bus_q.pop_front();
        chk("bus_we", 32'(mem_we), 32'(e.we));
        chk("bus_addr", mem_addr, e.a);
        chk("bus_be", 32'(mem_be), 32'(e.be));
        chk("bus_wdata", mem_wdata, e.wd);
      end
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
    end
    if (v.rd) begin
      for (int i = 0; i <= v.rdly; i++) begin
        if (i == v.rdly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.bus;
        end
        @(negedge clk);
        chk("wait_req", 32'(mem_req), 0);
        chk("wait_err", 32'(err), 0);
        st += int'(stall);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
    @(negedge clk);
    chk("done_stall", 32'(stall), 0);
    chk("done_err", 32'(err), 0);
    chk("done_req", 32'(mem_req), 0);
    chk("done_rdata", rdata, res_q.pop_front());
    chk("stall_cycles", 32'(st),
        32'(v.rd ? v.gdly + v.rdly + 3 : v.gdly + 2));
    clr_in();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int h0, pulses;
    tbl[0]  = '{0,1,3'b000,'h13,'hA5,0,0,0,4'h8,'hA5A5A5A5,0,0};
    tbl[1]  = '{1,0,3'b000,'h22,0,1,0,'h12F03456,4'h4,0,'hFFFFFFF0,0};
    tbl[2]  = '{1,0,3'b100,'h22,0,0,0,'h12F03456,4'h4,0,'h000000F0,0};
    tbl[3]  = '{1,0,3'b001,'h22,0,0,1,'h12F03456,4'hC,0,'h000012F0,0};
    tbl[4]  = '{0,1,3'b001,'h22,'hBEEF,1,0,0,4'hC,'hBEEFBEEF,'h000012F0,0};
    tbl[5]  = '{1,0,3'b101,'h20,0,0,2,'h8000F00D,4'h3,0,'h0000F00D,0};
    tbl[6]  = '{1,0,3'b001,'h20,0,0,0,'h8000F00D,4'h3,0,'hFFFFF00D,0};
    tbl[7]  = '{1,0,3'b000,'h01,0,0,0,'h00007F00,4'h2,0,'h0000007F,0};
    tbl[8]  = '{1,0,3'b010,'h44,0,3,3,'hCAFEF00D,4'hF,0,'hCAFEF00D,0};
    tbl[9]  = '{0,1,3'b010,'h48,'h11223344,0,0,0,4'hF,'h11223344,'hCAFEF00D,0};
    tbl[10] = '{0,1,3'b000,'h00,'hFFFFFF3C,0,0,0,4'h1,'h3C3C3C3C,'hCAFEF00D,0};
    tbl[11] = '{1,0,3'b010,'h06,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[12] = '{1,1,3'b010,'h00,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[13] = '{1,0,3'b001,'h03,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[14] = '{1,0,3'b011,'h00,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[15] = '{0,1,3'b100,'h00,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[16] = '{1,0,3'b111,'h00,0,0,0,0,0,0,'hCAFEF00D,1};
    tbl[17] = '{1,0,3'b000,'h03,0,0,0,'h85000000,4'h8,0,'hFFFFFF85,0};

    rst_n = 1'b0;
    clr_in();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;

    // reset while a load waits for data
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    clr_in();
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wrst_req", 32'(mem_req), 0);
    chk("wrst_we", 32'(mem_we), 0);
    chk("wrst_addr", mem_addr, 0);
    chk("wrst_wdata", mem_wdata, 0);
    chk("wrst_be", 32'(mem_be), 0);
    chk("wrst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    chk("wrst_rdata", rdata, 0);
    chk("wrst_err", 32'(err), 0);
    chk("wrst_stall2", 32'(stall), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) run_op(tbl[i]);

    // timeout: load granted, data withheld
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h50;
    @(posedge clk); #1;
    clr_in();
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (err) pulses++;
      if (k <= 3) chk("tmo_stall", 32'(stall), 1);
      if (k == 3) chk("tmo_err_at_3", 32'(err), 1);
      @(posedge clk); #1;
    end
    chk("tmo_pulses", 32'(pulses), 1);
    @(negedge clk);
    chk("tmo_idle", 32'(stall), 0);
    chk("tmo_rdata", rdata, 32'hFFFFFF85);
    @(posedge clk); #1;
    v = '{0,1,3'b010,'h60,'h5A5A0F0F,0,0,0,4'hF,'h5A5A0F0F,'hFFFFFF85,0};
    run_op(v);

    // store then load of the same word, back to back
    h0 = hs;
    v = '{0,1,3'b010,'h100,'h11223344,0,0,0,4'hF,'h11223344,'hFFFFFF85,0};
    run_op(v);
    v = '{1,0,3'b010,'h100,0,0,0,0,4'hF,0,'h11223344,0};
    v.bus = mem_m[8'h40];
    run_op(v);
    chk("b2b_handshakes", 32'(hs - h0), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
